// File: rtl/bus_selftest_sequencer.sv
// bus_selftest_sequencer
//
// Scripted traffic generator for the device side of a bus master port.
// On a start pulse it writes NUM_WORDS pattern bytes across an address
// window, reads them back, and compares each byte. It reports pass/fail,
// a saturating mismatch count and a timeout flag.
//
// Ports:
//   clk, rstn    - clock, synchronous active-low reset
//   start        - one-cycle pulse, begins a run (only honoured in IDLE)
//   d_valid/d_ready/d_mode/d_addr/d_wdata/d_rdata - request interface
//   busy         - run in progress
//   done         - run finished, held until next start or reset
//   pass         - valid with done: no mismatches and no timeout
//   err_count    - read mismatches, saturates at 255
//   timeout_err  - a request took TIMEOUT cycles without completing
//
// Handshake: a request is accepted on a cycle where d_valid and d_ready are
// both high; d_addr/d_mode/d_wdata hold steady from d_valid rising until
// that accept. After the accept d_valid drops, and the request completes
// once d_ready has been seen low and then high again. Read data is sampled
// in the cycle d_ready returns high.
module bus_selftest_sequencer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0000,
  parameter int                    ADDR_STRIDE = 1,
  parameter int                    NUM_WORDS   = 16,
  parameter logic [DATA_WIDTH-1:0] SEED        = 8'hA5,
  parameter int                    TIMEOUT     = 65535
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic                  d_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic                  timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [7:0]    LAST_IDX = 8'(NUM_WORDS - 1);
  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [7:0]    index;
  logic [TW-1:0] timer;
  logic          seen_low;

  logic          completion;
  logic          is_last;
  logic          rd_bad;
  logic [7:0]    next_idx;

  // Address wraps silently at ADDR_WIDTH; pattern wraps at DATA_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [7:0] i);
    return ADDR_WIDTH'(32'(BASE_ADDR) + 32'(i) * 32'(ADDR_STRIDE));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [7:0] i);
    return DATA_WIDTH'(32'(SEED) + 32'(i));
  endfunction

  assign completion = seen_low && d_ready;
  assign is_last    = (index == LAST_IDX);
  assign next_idx   = index + 8'd1;
  assign rd_bad     = (d_rdata != pattern_of(index));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      index       <= '0;
      timer       <= '0;
      seen_low    <= 1'b0;
      d_valid     <= 1'b0;
      d_mode      <= 1'b0;
      d_addr      <= '0;
      d_wdata     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            timeout_err <= 1'b0;
            index       <= '0;
            busy        <= 1'b1;
            timer       <= '0;
            d_valid     <= 1'b1;
            d_mode      <= 1'b1;
            d_addr      <= addr_of(8'd0);
            d_wdata     <= pattern_of(8'd0);
            state       <= S_WR_REQ;
          end
        end

        // d_valid is high for the whole REQ state, so d_ready alone is the accept.
        S_WR_REQ, S_RD_REQ: begin
          if (d_ready) begin
            d_valid  <= 1'b0;
            seen_low <= 1'b0;
            // Saturate so a late accept still times out on the first WAIT cycle.
            if (timer != T_LAST) timer <= timer + TW'(1);
            state <= (state == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            d_valid     <= 1'b0;
            state       <= S_FINISH;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_WR_WAIT, S_RD_WAIT: begin
          if (!d_ready) seen_low <= 1'b1;
          if (completion) begin
            timer <= '0;
            if (state == S_RD_WAIT && rd_bad && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            if (!is_last) begin
              index   <= next_idx;
              d_valid <= 1'b1;
              d_addr  <= addr_of(next_idx);
              d_wdata <= (state == S_WR_WAIT) ? pattern_of(next_idx) : '0;
              state   <= (state == S_WR_WAIT) ? S_WR_REQ : S_RD_REQ;
            end else if (state == S_WR_WAIT) begin
              index   <= '0;
              d_valid <= 1'b1;
              d_mode  <= 1'b0;
              d_addr  <= addr_of(8'd0);
              d_wdata <= '0;
              state   <= S_RD_REQ;
            end else begin
              index <= '0;
              state <= S_FINISH;
            end
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_FINISH;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 8'd0) && !timeout_err;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_selftest_sequencer.sv
// tb_bus_selftest_sequencer
//
// Two sequencer instances share one responder memory model: dut0 uses the
// default window (TIMEOUT shortened to 100), dut1 uses a window that wraps
// through 0xFFFF. A mux selects which instance the responder and monitor
// follow. Expected request streams and run results are derived from the
// address/pattern rules and pushed into queues when a run is started.
module tb_bus_selftest_sequencer;

  localparam int TMO = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        start0, start1, sel;
  logic        d_ready = 1'b1;
  logic [7:0]  d_rdata = 8'h00;

  logic [7:0]  wdata0, wdata1, err0, err1;
  logic [15:0] addr0, addr1;
  logic        valid0, mode0, busy0, done0, pass0, tmo0;
  logic        valid1, mode1, busy1, done1, pass1, tmo1;

  logic [7:0]  m_wdata, m_err;
  logic [15:0] m_addr;
  logic        m_valid, m_mode, m_busy, m_done, m_pass, m_tmo;

  assign m_wdata = sel ? wdata1 : wdata0;
  assign m_err   = sel ? err1   : err0;
  assign m_addr  = sel ? addr1  : addr0;
  assign m_valid = sel ? valid1 : valid0;
  assign m_mode  = sel ? mode1  : mode0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_pass  = sel ? pass1  : pass0;
  assign m_tmo   = sel ? tmo1   : tmo0;

  bus_selftest_sequencer #(.TIMEOUT(TMO)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0),
    .d_wdata(wdata0), .d_rdata(d_rdata), .d_addr(addr0), .d_valid(valid0),
    .d_ready(d_ready), .d_mode(mode0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .timeout_err(tmo0)
  );

  bus_selftest_sequencer #(.BASE_ADDR(16'hFFFE), .NUM_WORDS(4), .SEED(8'hFE),
                           .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1),
    .d_wdata(wdata1), .d_rdata(d_rdata), .d_addr(addr1), .d_valid(valid1),
    .d_ready(d_ready), .d_mode(mode1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .timeout_err(tmo1)
  );

  // scoreboard state
  logic [24:0] exp_q[$];   // {mode, addr, wdata} per expected request
  logic [9:0]  res_q[$];   // {pass, err_count, timeout_err} per run
  int n_cmp  = 0;
  int n_fail = 0;
  int runs_done = 0;
  int acc_wr = 0;

  // responder configuration, set by the stimulus process while idle
  bit   lat_rand   = 1'b0;
  int   hang_after = 0;
  bit   corrupt [0:65535];
  logic [7:0] mem [0:65535];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: expected requests and result of one run
  task automatic expect_run(input int base, input int stride, input int n,
                            input int seed, input int hang_w);
    int errs;
    bit to;
    logic [15:0] a;
    logic [7:0]  dv;
    errs = 0;
    to = (hang_w != 0);
    for (int i = 0; i < n; i++) begin
      if (!to || i < hang_w) begin
        a  = 16'((base + i * stride) % 65536);
        dv = 8'((seed + i) % 256);
        exp_q.push_back({1'b1, a, dv});
      end
    end
    if (!to) begin
      for (int i = 0; i < n; i++) begin
        a = 16'((base + i * stride) % 65536);
        exp_q.push_back({1'b0, a, 8'h00});
        if (corrupt[a]) errs++;
      end
    end
    if (errs > 255) errs = 255;
    res_q.push_back({(errs == 0 && !to), 8'(errs), to});
  endtask

  // responder + monitor (one process so d_ready is never read mid-update)
  int          busy_cnt = 0;
  int          wr_cnt = 0;
  bit          hang = 1'b0;
  bit          pend_read = 1'b0;
  logic [15:0] pend_addr = '0;
  logic        prev_valid = 1'b0, prev_ready = 1'b1, prev_done = 1'b0, prev_tmo = 1'b0;
  logic [24:0] prev_req = '0;
  int          entry_cyc = 0;
  logic [24:0] e;
  logic [9:0]  r;

  always @(negedge clk) begin
    if (!m_busy) begin
      busy_cnt = 0;
      hang = 1'b0;
      wr_cnt = 0;
    end
    if (hang) begin
      d_ready = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      d_ready = (busy_cnt == 0);
      if (busy_cnt == 0 && pend_read)
        d_rdata = mem[pend_addr] ^ {7'd0, corrupt[pend_addr]};
    end else begin
      d_ready = lat_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    if (m_valid && d_ready) begin
      if (m_mode) begin
        mem[m_addr] = m_wdata;
        wr_cnt++;
        acc_wr++;
        if (hang_after != 0 && wr_cnt == hang_after) hang = 1'b1;
      end
      pend_read = !m_mode;
      pend_addr = m_addr;
      busy_cnt  = lat_rand ? int'($urandom_range(2, 8)) : 5;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL request: actual %0h required none (cycle %0d)", {m_mode, m_addr, m_wdata}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("request", {7'd0, m_mode, m_addr, m_wdata}, {7'd0, e});
      end
    end

    if (prev_valid && !prev_ready) begin
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_req", {7'd0, m_mode, m_addr, m_wdata}, {7'd0, prev_req});
    end

    if (m_valid && !prev_valid) entry_cyc = cyc;

    if (m_tmo && !prev_tmo) begin
      check("timeout_latency", cyc - entry_cyc, TMO);
      check("timeout_valid", {31'd0, m_valid}, 32'd0);
    end

    if (m_done && !prev_done) begin
      if (res_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL result: actual %0h required none (cycle %0d)", {m_pass, m_err, m_tmo}, cyc);
      end else begin
        r = res_q.pop_front();
        check("result", {22'd0, m_pass, m_err, m_tmo}, {22'd0, r});
      end
      runs_done++;
    end

    prev_valid = m_valid;
    prev_ready = d_ready;
    prev_done  = m_done;
    prev_tmo   = m_tmo;
    prev_req   = {m_mode, m_addr, m_wdata};
  end

  // driver tasks
  task automatic pulse_start(input bit fresh);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    if (fresh) begin
      check("start_busy",  {31'd0, m_busy},  32'd1);
      check("start_done",  {31'd0, m_done},  32'd0);
      check("start_err",   {24'd0, m_err},   32'd0);
      check("start_valid", {31'd0, m_valid}, 32'd1);
    end
  endtask

  task automatic wait_done(input int budget);
    int target;
    int k;
    target = runs_done + 1;
    k = 0;
    while (runs_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (runs_done < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_done: actual no done required done within %0d cycles", budget);
    end
  endtask

  task automatic wait_writes(input int count, input int budget);
    int k;
    k = 0;
    while (acc_wr < count && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (acc_wr < count) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_writes: actual %0d required %0d accepts", acc_wr, count);
    end
  endtask

  task automatic clear_corrupt();
    for (int a = 0; a < 16; a++) corrupt[a] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rstn = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("reset_req0",    {7'd0, valid0, mode0, addr0, wdata0}, 32'd0);
    check("reset_status0", {20'd0, busy0, done0, pass0, err0, tmo0}, 32'd0);
    check("reset_req1",    {7'd0, valid1, mode1, addr1, wdata1}, 32'd0);
    check("reset_status1", {20'd0, busy1, done1, pass1, err1, tmo1}, 32'd0);

    // default window, ideal responder
    expect_run(0, 1, 16, 8'hA5, 0);
    pulse_start(1'b1);
    wait_done(2000);

    // corrupted read data at 0x0003 and 0x0007
    corrupt[3] = 1'b1;
    corrupt[7] = 1'b1;
    expect_run(0, 1, 16, 8'hA5, 0);
    pulse_start(1'b1);
    wait_done(2000);
    clear_corrupt();

    // responder hangs after the 5th write accept
    hang_after = 5;
    expect_run(0, 1, 16, 8'hA5, 5);
    pulse_start(1'b1);
    wait_done(2000);
    hang_after = 0;

    // reset while waiting on word 3's write
    base = acc_wr;
    expect_run(0, 1, 16, 8'hA5, 0);
    pulse_start(1'b1);
    wait_writes(base + 4, 500);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrun_reset_req",    {7'd0, m_valid, m_mode, m_addr, m_wdata}, 32'd0);
    check("midrun_reset_status", {20'd0, m_busy, m_done, m_pass, m_err, m_tmo}, 32'd0);
    exp_q.delete();
    res_q.delete();
    repeat (30) begin
      @(negedge clk);
      check("idle_after_reset", {31'd0, m_valid}, 32'd0);
    end

    // wrapping window on dut1
    sel = 1'b1;
    @(negedge clk);
    expect_run(16'hFFFE, 1, 4, 8'hFE, 0);
    pulse_start(1'b1);
    wait_done(1000);
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // start mid-run is ignored; start right after done begins a clean run
    corrupt[3] = 1'b1;
    corrupt[7] = 1'b1;
    base = acc_wr;
    expect_run(0, 1, 16, 8'hA5, 0);
    pulse_start(1'b1);
    wait_writes(base + 6, 500);
    pulse_start(1'b0);
    wait_done(2000);
    clear_corrupt();
    expect_run(0, 1, 16, 8'hA5, 0);
    pulse_start(1'b1);
    wait_done(2000);

    // randomized latency, ready stalls and corruption
    lat_rand = 1'b1;
    for (int run = 0; run < 6; run++) begin
      for (int a = 0; a < 16; a++) corrupt[a] = ($urandom_range(0, 3) == 0);
      expect_run(0, 1, 16, 8'hA5, 0);
      pulse_start(1'b1);
      wait_done(3000);
      clear_corrupt();
    end
    lat_rand = 1'b0;

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("res_q_drained", res_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_selftest_sequencer.md
Name: bus_selftest_sequencer

Overview:
- Scripted traffic generator on the device side of master 1 of the 2-master/3-slave system bus top level.
- Drives the d1_* request interface: writes NUM_WORDS pattern bytes across an address window, reads them back, and compares each byte.
- Reports pass/fail, mismatch count and timeout status.
- Used for board bring-up and for regressing the bus, the slaves and the UART bus-bridge path without a host.

Parameters:
- ADDR_WIDTH, 16, width of d_addr; matches the bus device address.
- DATA_WIDTH, 8, width of d_wdata/d_rdata.
- BASE_ADDR, 16'h0000, first address of the test window.
- ADDR_STRIDE, 1, address increment per word.
- NUM_WORDS, 16, words written then read, 1..256.
- SEED, 8'hA5, pattern seed.
- TIMEOUT, 65535, max cycles per request (accept plus completion); sized for bridge/UART latency.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a test run.
- d_wdata  out  DATA_WIDTH  write data to master port.
- d_rdata  in  DATA_WIDTH  read data from master port.
- d_addr  out  ADDR_WIDTH  request address.
- d_valid  out  1  request valid.
- d_ready  in  1  master port ready.
- d_mode  out  1  0 = read, 1 = write.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  valid when done; 1 = zero mismatches and no timeout.
- err_count  out  8  mismatch count, saturates at 255.
- timeout_err  out  1  a request exceeded TIMEOUT.

Behaviour:
- Single clock clk.
- Reset: rstn sampled on the clk rising edge only, active low.
- Reset values: state IDLE, d_valid 0, d_mode 0, d_addr 0, d_wdata 0, busy 0, done 0, pass 0, err_count 0, timeout_err 0, index 0, timer 0.
- Reset mid-run aborts immediately; no further requests are issued.
- Addressing and data:
  - addr(i) = (BASE_ADDR + i*ADDR_STRIDE) truncated to ADDR_WIDTH; wrap-around is silent.
  - pattern(i) = (SEED + i) mod 2^DATA_WIDTH, with i = 0..NUM_WORDS-1.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH.
- IDLE:
  - start=1 clears done, pass, err_count, timeout_err and index, sets busy, and enters WR_REQ next cycle.
- WR_REQ:
  - d_valid=1, d_mode=1, d_addr=addr(index), d_wdata=pattern(index).
  - Accept occurs on a cycle with d_valid & d_ready; next cycle d_valid=0 and go to WR_WAIT.
- WR_WAIT:
  - Completion = d_ready observed low, then observed high again. The seen_low flag is cleared on WAIT entry.
  - On completion: if index == NUM_WORDS-1, set index to 0 and go to RD_REQ; else increment index and go to WR_REQ.
- RD_REQ: same as WR_REQ, with d_mode=0 and d_wdata held 0.
- RD_WAIT:
  - On completion, sample d_rdata in the same cycle d_ready returns high.
  - If d_rdata != pattern(index), increment err_count (saturating).
  - Then advance index, or go to FINISH after the last word.
- Outputs are stable while d_valid=1; d_addr/d_mode/d_wdata never change before accept.
- Timer:
  - Cleared on entry to each REQ state; counts through REQ and WAIT.
  - When timer == TIMEOUT-1 without completion: set timeout_err, drop d_valid, go to FINISH.
- FINISH (one cycle): busy=0, done=1, pass = (err_count==0) & ~timeout_err; return to IDLE.
- start while busy is ignored.
- start in IDLE with done=1 starts a new run.
- start and an accept in the same cycle: start is ignored.
- NUM_WORDS=1: exactly one write then one read.

Test Plan:
- Reset during WR_WAIT of word 3 (rstn low 1 cycle) -> all outputs at reset values next cycle; d_valid stays 0 thereafter until start.
- Defaults with an ideal responder memory (ready drops 1 cycle after accept, returns 4 cycles later) -> 16 writes to 0x0000..0x000F with data 0xA5..0xB4, 16 reads; done=1, pass=1, err_count=0.
- Responder corrupts read data at addresses 0x0003 and 0x0007 (bit 0 flipped) -> done=1, pass=0, err_count=2, timeout_err=0.
- Responder never returns d_ready high after the 5th write accept, TIMEOUT=100 -> timeout_err=1 exactly 100 cycles after WR_REQ entry for that word; d_valid=0; done=1, pass=0.
- BASE_ADDR=16'hFFFE, ADDR_STRIDE=1, NUM_WORDS=4 -> addresses FFFE, FFFF, 0000, 0001; SEED=8'hFE gives data FE, FF, 00, 01; pass=1.
- start pulsed mid-run and again one cycle after done -> mid-run pulse ignored (no index change); second run clears err_count and repeats the full sequence.
